jtopl_lfo: RTL and testbench

JTOPL_LFO -- requirements
Module: jtopl_lfo

---
 rtl/jtopl_lfo.sv | 74 +++++++
 tb/tb_jtopl_lfo.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtopl_lfo.sv
// jtopl_lfo: vibrato and tremolo low-frequency oscillators for the OPL core.
//
// Ports:
//   clk      system clock, all flops on its rising edge
//   rst      synchronous active-high reset
//   cenop    operator-rate clock enable
//   zero     high during the slot-0 cenop of each sample
//   am_dep   tremolo depth select (1 = 4.8 dB, 0 = 1 dB)
//   vib_cnt  vibrato position {sign, half-cycle direction, step[2:0]}
//   trem     tremolo attenuation added to the envelope, 0..26
//
// A shared 8-bit prescaler advances once per sample. Vibrato steps every
// 256 samples, tremolo every 64 samples over a 210-step triangle.

module jtopl_lfo (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    input  logic       zero,
    input  logic       am_dep,
    output logic [4:0] vib_cnt,
    output logic [4:0] trem
);

    logic       tick;
    logic [7:0] pre_cnt;
    logic [7:0] am_pos;
    logic [6:0] am_val;
    logic [4:0] trem_d;

    assign tick = cenop & zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= 8'd0;
            vib_cnt <= 5'd0;
            am_pos  <= 8'd0;
        end else if (tick) begin
            pre_cnt <= pre_cnt + 8'd1;
            if (pre_cnt == 8'hff)
                vib_cnt <= vib_cnt + 5'd1;
            // Anything at or past the last valid step (209) folds back to 0,
            // so an out-of-range position can never persist.
            if (pre_cnt[5:0] == 6'h3f)
                am_pos <= (am_pos >= 8'd209) ? 8'd0 : am_pos + 8'd1;
        end
    end

    // Triangle: rises 0..104 for the first half, falls back for the second.
    always_comb begin
        am_val = 7'd0;
        if (am_pos <= 8'd104)
            am_val = 7'(am_pos);
        else
            am_val = 7'(8'd209 - am_pos);
    end

    always_comb begin
        trem_d = 5'd0;
        if (am_dep)
            trem_d = 5'(am_val >> 2);
        else
            trem_d = 5'(am_val >> 4);
    end

    // Not gated by the tick: trem follows am_pos/am_dep one cycle later.
    always_ff @(posedge clk) begin
        if (rst)
            trem <= 5'd0;
        else
            trem <= trem_d;
    end

endmodule

// File: tb/tb_jtopl_lfo.sv
module tb_jtopl_lfo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cenop = 1'b0;
    logic       zero = 1'b0;
    logic       am_dep = 1'b1;
    logic [4:0] vib_cnt;
    logic [4:0] trem;

    int checks = 0;
    int errors = 0;
    int n = 0;  // ticks since last reset (reference model state)

    always #5 clk = ~clk;

    jtopl_lfo dut (
        .clk    (clk),
        .rst    (rst),
        .cenop  (cenop),
        .zero   (zero),
        .am_dep (am_dep),
        .vib_cnt(vib_cnt),
        .trem   (trem)
    );

    // Reference model: everything derived from the tick count.
    function automatic int m_pre(int t);  return t % 256; endfunction
    function automatic int m_vib(int t);  return (t / 256) % 32; endfunction
    function automatic int m_am(int t);   return (t / 64) % 210; endfunction
    function automatic int m_trem(int pos, logic dep);
        int v;
        v = (pos <= 104) ? pos : 209 - pos;
        return dep ? v / 4 : v / 16;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n = 0;
    endtask

    task automatic tick_n(int k);
        cenop = 1'b1;
        zero = 1'b1;
        repeat (k) cycle();
        cenop = 1'b0;
        zero = 1'b0;
        n += k;
    endtask

    task automatic test_reset();
        cenop = 1'b1; zero = 1'b1;
        do_reset();
        cenop = 1'b0; zero = 1'b0;
        checks++;
        if (vib_cnt !== 5'd0 || trem !== 5'd0 || dut.pre_cnt !== 8'd0 || dut.am_pos !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: vib=%0h trem=%0h pre=%0h am=%0h, required all 0",
                     vib_cnt, trem, dut.pre_cnt, dut.am_pos);
        end
        tick_n(5);
        cycle();
        checks++;
        if (dut.pre_cnt !== 8'd5 || vib_cnt !== 5'd0 || dut.am_pos !== 8'd0 || trem !== 5'd0) begin
            errors++;
            $display("FAIL reset_5ticks: pre=%0d vib=%0d am=%0d trem=%0d, required 5 0 0 0",
                     dut.pre_cnt, vib_cnt, dut.am_pos, trem);
        end
    endtask

    task automatic test_vibrato();
        logic seen31;
        seen31 = 1'b0;
        do_reset();
        tick_n(255);
        checks++;
        if (vib_cnt !== 5'd0) begin
            errors++;
            $display("FAIL vib_255: got %0d required 0", vib_cnt);
        end
        tick_n(1);
        checks++;
        if (vib_cnt !== 5'd1 || dut.pre_cnt !== 8'd0) begin
            errors++;
            $display("FAIL vib_256: vib=%0d pre=%0d required 1 0", vib_cnt, dut.pre_cnt);
        end
        while (n < 8192) begin
            tick_n(1);
            if (vib_cnt === 5'd31) seen31 = 1'b1;
        end
        checks++;
        if (vib_cnt !== 5'd0 || !seen31) begin
            errors++;
            $display("FAIL vib_wrap: vib=%0d seen31=%0b required 0 1", vib_cnt, seen31);
        end
    endtask

    task automatic test_tremolo();
        do_reset();
        am_dep = 1'b1;
        tick_n(6720);
        checks++;
        if (dut.am_pos !== 8'(m_am(n)) || m_am(n) != 105) begin
            errors++;
            $display("FAIL trem_peak_pos: am_pos=%0d required 105", dut.am_pos);
        end
        cycle();
        checks++;
        if (trem !== 5'd26) begin
            errors++;
            $display("FAIL trem_peak_dep1: got %0d required 26", trem);
        end
        am_dep = 1'b0;
        cycle();
        checks++;
        if (trem !== 5'd6) begin
            errors++;
            $display("FAIL trem_peak_dep0: got %0d required 6", trem);
        end
        am_dep = 1'b1;
        tick_n(13440 - 6720);
        cycle();
        checks++;
        if (dut.am_pos !== 8'd0 || trem !== 5'd0 || vib_cnt !== 5'(m_vib(n))) begin
            errors++;
            $display("FAIL trem_wrap: am_pos=%0d trem=%0d vib=%0d required 0 0 %0d",
                     dut.am_pos, trem, vib_cnt, m_vib(n));
        end
    endtask

    task automatic test_gating();
        logic [7:0] pre0, am0;
        logic [4:0] vib0;
        do_reset();
        tick_n(300);
        pre0 = 8'(m_pre(n)); am0 = 8'(m_am(n)); vib0 = 5'(m_vib(n));
        cenop = 1'b1; zero = 1'b0;
        repeat (1000) cycle();
        checks++;
        if (dut.pre_cnt !== pre0 || dut.am_pos !== am0 || vib_cnt !== vib0) begin
            errors++;
            $display("FAIL gate_cenop_only: pre=%0d am=%0d vib=%0d required %0d %0d %0d",
                     dut.pre_cnt, dut.am_pos, vib_cnt, pre0, am0, vib0);
        end
        cenop = 1'b0; zero = 1'b1;
        repeat (200) cycle();
        zero = 1'b0;
        checks++;
        if (dut.pre_cnt !== pre0 || dut.am_pos !== am0 || vib_cnt !== vib0) begin
            errors++;
            $display("FAIL gate_zero_only: pre=%0d am=%0d vib=%0d required %0d %0d %0d",
                     dut.pre_cnt, dut.am_pos, vib_cnt, pre0, am0, vib0);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        tick_n(5000);
        checks++;
        if (vib_cnt !== 5'd19 || dut.am_pos !== 8'd78) begin
            errors++;
            $display("FAIL midrst_pre: vib=%0d am=%0d required 19 78", vib_cnt, dut.am_pos);
        end
        cenop = 1'b1; zero = 1'b1;
        do_reset();
        checks++;
        if (vib_cnt !== 5'd0 || trem !== 5'd0 || dut.pre_cnt !== 8'd0 || dut.am_pos !== 8'd0) begin
            errors++;
            $display("FAIL midrst_tick: vib=%0d trem=%0d pre=%0d am=%0d required all 0",
                     vib_cnt, trem, dut.pre_cnt, dut.am_pos);
        end
        cycle();
        n = 1;
        cenop = 1'b0; zero = 1'b0;
        checks++;
        if (dut.pre_cnt !== 8'd1 || vib_cnt !== 5'd0 || dut.am_pos !== 8'd0) begin
            errors++;
            $display("FAIL midrst_restart: pre=%0d vib=%0d am=%0d required 1 0 0",
                     dut.pre_cnt, vib_cnt, dut.am_pos);
        end
    endtask

    task automatic test_random();
        int exp_trem;
        int bad;
        bad = 0;
        do_reset();
        exp_trem = 0;
        tick_n(6400);  // start near the top of the triangle
        cycle();
        exp_trem = m_trem(m_am(n), am_dep);
        for (int i = 0; i < 4000; i++) begin
            cenop = 1'($urandom_range(0, 1));
            zero = ($urandom_range(0, 3) != 0);
            am_dep = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 499) == 0);
            @(posedge clk);
            if (rst) begin
                n = 0;
                exp_trem = 0;
            end else begin
                exp_trem = m_trem(m_am(n), am_dep);
                if (cenop && zero) n++;
            end
            #1;
            checks++;
            if (vib_cnt !== 5'(m_vib(n)) || trem !== 5'(exp_trem) || dut.pre_cnt !== 8'(m_pre(n))) begin
                errors++;
                if (bad < 5)
                    $display("FAIL random[%0d]: vib=%0d trem=%0d pre=%0d required %0d %0d %0d",
                             i, vib_cnt, trem, dut.pre_cnt, m_vib(n), exp_trem, m_pre(n));
                bad++;
            end
        end
        rst = 1'b0; cenop = 1'b0; zero = 1'b0;
    endtask

    task automatic test_symmetry();
        int t1[210];
        int t0[210];
        do_reset();
        for (int p = 0; p < 210; p++) begin
            am_dep = 1'b1; cycle();
            t1[p] = int'(trem);
            am_dep = 1'b0; cycle();
            t0[p] = int'(trem);
            checks++;
            if (t1[p] != m_trem(p, 1'b1) || t0[p] != m_trem(p, 1'b0)) begin
                errors++;
                $display("FAIL sym_value[%0d]: trem1=%0d trem0=%0d required %0d %0d",
                         p, t1[p], t0[p], m_trem(p, 1'b1), m_trem(p, 1'b0));
            end
            tick_n(64);
        end
        for (int k = 0; k <= 104; k++) begin
            checks++;
            if (t1[k] != t1[209-k] || t0[k] != t0[209-k]) begin
                errors++;
                $display("FAIL sym_pair[%0d]: %0d/%0d vs %0d/%0d required equal",
                         k, t1[k], t0[k], t1[209-k], t0[209-k]);
            end
        end
        checks++;
        if (dut.am_pos !== 8'd0) begin
            errors++;
            $display("FAIL sym_wrap: am_pos=%0d required 0", dut.am_pos);
        end
    endtask

    initial begin
        cycle();
        test_reset();
        test_vibrato();
        test_tremolo();
        test_gating();
        test_mid_reset();
        test_random();
        test_symmetry();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
